// File: rtl/data_mem_responder_pkg.sv
// Shared types for the stage-4 data-memory responder: access sizes, FSM states
// and the size-to-byte-count helper.
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        MEM_B = 2'd0,
        MEM_H = 2'd1,
        MEM_W = 2'd2,
        MEM_D = 2'd3
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } dmr_state_t;

    function automatic logic [3:0] size_bytes(input mem_size_t size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/data_mem_responder_mem_lane_align.sv
// Byte-lane steering between a 64-bit memory word and a right-justified access:
// store byte enables and shifted data, plus load extraction with extension.
module mem_lane_align
    import riscv_mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [2:0]  byte_off,
    input  logic [63:0] word_in,
    input  logic [63:0] data_in,
    output logic [7:0]  byte_en,
    output logic [63:0] store_data,
    output logic [63:0] load_data
);

    logic [3:0]  nbytes;
    logic [63:0] shifted;

    always_comb begin
        // NOTE: every output of a combinational block gets a value before any
        // branch, so no path through the case can leave a latch behind.
        nbytes     = size_bytes(mem_size_t'(size));
        byte_en    = 8'((9'd1 << nbytes) - 9'd1) << byte_off;
        store_data = data_in << {byte_off, 3'b000};
        shifted    = word_in >> {byte_off, 3'b000};
        load_data  = shifted;

        case (mem_size_t'(size))
            MEM_B: load_data = is_unsigned ? {56'd0, shifted[7:0]}
                                           : {{56{shifted[7]}}, shifted[7:0]};
            MEM_H: load_data = is_unsigned ? {48'd0, shifted[15:0]}
                                           : {{48{shifted[15]}}, shifted[15:0]};
            MEM_W: load_data = is_unsigned ? {32'd0, shifted[31:0]}
                                           : {{32{shifted[31]}}, shifted[31:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the data-memory interface: single outstanding request,
// alignment/range check, WAIT_CYCLES wait states, one-cycle response strobe.
module data_mem_responder
    import riscv_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_W      = 48
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [63:0]       mem_data_in,
    output logic              resp_valid,
    output logic [63:0]       mem_data_out,
    output logic              resp_err
);

    localparam int                IDX_W       = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_W-4:0] DEPTH_LIMIT = (ADDR_W-3)'(DEPTH_WORDS);

    dmr_state_t       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [63:0]      rdata_q, rdata_d;

    logic             we_q, we_d;
    logic [1:0]       size_q, size_d;
    logic             uns_q, uns_d;
    logic [2:0]       off_q, off_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [63:0]      wdata_q, wdata_d;

    logic [63:0]      mem [DEPTH_WORDS];

    logic             accept;
    logic             misaligned;
    logic             out_of_range;
    logic             commit;
    logic [63:0]      word_rd;
    logic [7:0]       byte_en;
    logic [63:0]      store_data;
    logic [63:0]      load_data;

    assign req_ready    = (state_q == IDLE);
    assign resp_valid   = (state_q == RESP);
    assign resp_err     = err_q;
    assign mem_data_out = rdata_q;

    assign accept       = req_valid && req_ready;
    assign misaligned   = (mem_addr[2:0] & 3'(size_bytes(mem_size_t'(req_size)) - 4'd1)) != 3'd0;
    assign out_of_range = mem_addr[ADDR_W-1:3] >= DEPTH_LIMIT;
    assign word_rd      = mem[idx_q];
    assign commit       = (state_q == BUSY) && (cnt_q == 4'd0) && we_q;

    mem_lane_align u_lane_align (
        .size        (size_q),
        .is_unsigned (uns_q),
        .byte_off    (off_q),
        .word_in     (word_rd),
        .data_in     (wdata_q),
        .byte_en     (byte_en),
        .store_data  (store_data),
        .load_data   (load_data)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        off_d   = off_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    off_d   = mem_addr[2:0];
                    idx_d   = mem_addr[3 +: IDX_W];
                    wdata_d = mem_data_in;
                    rdata_d = 64'd0;
                    if (misaligned || out_of_range) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        err_d   = 1'b0;
                        cnt_d   = 4'(WAIT_CYCLES);
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rdata_d = we_q ? 64'd0 : load_data;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state flops use non-blocking assignment so every flop samples
        // the pre-edge values regardless of statement order.
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
            rdata_q <= 64'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Captured request fields are only consumed after an accept, so they need no reset.
    always_ff @(posedge clk) begin
        we_q    <= we_d;
        size_q  <= size_d;
        uns_q   <= uns_d;
        off_q   <= off_d;
        idx_q   <= idx_d;
        wdata_q <= wdata_d;
    end

    // NOTE: the backing store is deliberately never reset; clearing it would turn
    // the array into flops. Reset only blocks a pending write from committing.
    always_ff @(posedge clk) begin
        if (!reset && commit) begin
            for (int b = 0; b < 8; b++) begin
                if (byte_en[b]) begin
                    mem[idx_q][8*b +: 8] <= store_data[8*b +: 8];
                end
            end
        end
    end

endmodule
